// File: rtl/ctrl_pipe_if.sv
// ============================================================================
// Module   : ctrl_pipe_if
// Brief    : ID-stage inputs and per-stage control outputs of ctrl_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ctrl_pipe_if #(
    parameter int OPW = 6,
    parameter int RW  = 5
);
    logic           valid_id;
    logic [OPW-1:0] opcode_id;
    logic [RW-1:0]  rs_id;
    logic [RW-1:0]  rt_id;
    logic [RW-1:0]  rd_id;
    logic           zero_ex;

    logic           alusrc_ex;
    logic           regdst_ex;
    logic           branch_ex;
    logic           memread_ex;
    logic [2:0]     aluop_ex;
    logic           memread_mem;
    logic           memwrite_mem;
    logic           wen_wb;
    logic           memtoreg_wb;
    logic           jal_wb;
    logic [RW-1:0]  wdst_ex;
    logic [RW-1:0]  wdst_mem;
    logic [RW-1:0]  wdst_wb;
    logic           valid_ex;
    logic           valid_mem;
    logic           valid_wb;
    logic           pc_stall;
    logic           ifid_stall;
    logic           ifid_flush;
    logic [1:0]     pc_sel;

    modport master (
        output valid_id, opcode_id, rs_id, rt_id, rd_id, zero_ex,
        input  alusrc_ex, regdst_ex, branch_ex, memread_ex, aluop_ex,
        input  memread_mem, memwrite_mem, wen_wb, memtoreg_wb, jal_wb,
        input  wdst_ex, wdst_mem, wdst_wb, valid_ex, valid_mem, valid_wb,
        input  pc_stall, ifid_stall, ifid_flush, pc_sel
    );

    modport slave (
        input  valid_id, opcode_id, rs_id, rt_id, rd_id, zero_ex,
        output alusrc_ex, regdst_ex, branch_ex, memread_ex, aluop_ex,
        output memread_mem, memwrite_mem, wen_wb, memtoreg_wb, jal_wb,
        output wdst_ex, wdst_mem, wdst_wb, valid_ex, valid_mem, valid_wb,
        output pc_stall, ifid_stall, ifid_flush, pc_sel
    );
endinterface

`default_nettype wire

// File: rtl/ctrl_pipe.sv
// ============================================================================
// Module   : ctrl_pipe
// Brief    : Pipelined control unit: ID decode, ID/EX-EX/MEM-MEM/WB control
//            registers, load-use stall and branch/jump redirect resolution.
//            Optional macro HAZARD_EN enables load-use stall insertion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_pipe #(
    parameter int            OPW    = 6,
    parameter int            RW     = 5,
    parameter logic [RW-1:0] REG_RA = {RW{1'b1}}
) (
    input  logic       clk,
    input  logic       rst_n,
    ctrl_pipe_if.slave bus
);

    // Opcode map shared with the datapath's define.v
    localparam logic [OPW-1:0] c_op_add  = OPW'(6'd0);
    localparam logic [OPW-1:0] c_op_sub  = OPW'(6'd1);
    localparam logic [OPW-1:0] c_op_and  = OPW'(6'd2);
    localparam logic [OPW-1:0] c_op_xor  = OPW'(6'd3);
    localparam logic [OPW-1:0] c_op_com  = OPW'(6'd4);
    localparam logic [OPW-1:0] c_op_mul  = OPW'(6'd5);
    localparam logic [OPW-1:0] c_op_addi = OPW'(6'd8);
    localparam logic [OPW-1:0] c_op_lw   = OPW'(6'd9);
    localparam logic [OPW-1:0] c_op_sw   = OPW'(6'd10);
    localparam logic [OPW-1:0] c_op_beq  = OPW'(6'd11);
    localparam logic [OPW-1:0] c_op_j    = OPW'(6'd12);
    localparam logic [OPW-1:0] c_op_jal  = OPW'(6'd13);
    localparam logic [OPW-1:0] c_op_jr   = OPW'(6'd14);

    localparam logic [1:0] c_sel_pc4    = 2'b00;
    localparam logic [1:0] c_sel_branch = 2'b01;
    localparam logic [1:0] c_sel_jump   = 2'b10;
    localparam logic [1:0] c_sel_jr     = 2'b11;

    typedef struct packed {
        logic          valid;
        logic          wen;
        logic          alusrc;
        logic          regdst;
        logic          memread;
        logic          memwrite;
        logic          memtoreg;
        logic          branch;
        logic          jal;
        logic [2:0]    aluop;
        logic [RW-1:0] wdst;
    } idex_t;

    typedef struct packed {
        logic          valid;
        logic          wen;
        logic          memread;
        logic          memwrite;
        logic          memtoreg;
        logic          jal;
        logic [RW-1:0] wdst;
    } exmem_t;

    typedef struct packed {
        logic          valid;
        logic          wen;
        logic          memtoreg;
        logic          jal;
        logic [RW-1:0] wdst;
    } memwb_t;

    idex_t  w_dec;
    logic   w_reads_rs;
    logic   w_reads_rt;
    logic   w_jump;
    logic   w_jr;
    logic   w_branch_taken;
    logic   w_load_use;
    logic   w_idex_bubble;
    logic   w_pc_stall;
    logic   w_ifid_stall;
    logic   w_ifid_flush;
    logic [1:0] w_pc_sel;

    idex_t  r_idex;
    exmem_t r_exmem;
    memwb_t r_memwb;

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    always_comb begin
        w_dec      = '0;
        w_reads_rs = 1'b0;
        w_reads_rt = 1'b0;
        w_jump     = 1'b0;
        w_jr       = 1'b0;
        if (bus.valid_id) begin
            case (bus.opcode_id)
                c_op_add, c_op_sub, c_op_and, c_op_xor, c_op_com, c_op_mul: begin
                    w_dec.valid    = 1'b1;
                    w_dec.wen      = 1'b1;
                    w_dec.regdst   = 1'b1;
                    w_dec.memtoreg = 1'b1;
                    w_dec.aluop    = bus.opcode_id[2:0];
                    w_reads_rs     = 1'b1;
                    w_reads_rt     = 1'b1;
                end
                c_op_addi: begin
                    // memtoreg=1 selects the ALU result on writeback
                    w_dec.valid    = 1'b1;
                    w_dec.wen      = 1'b1;
                    w_dec.alusrc   = 1'b1;
                    w_dec.memtoreg = 1'b1;
                    w_reads_rs     = 1'b1;
                end
                c_op_lw: begin
                    w_dec.valid   = 1'b1;
                    w_dec.wen     = 1'b1;
                    w_dec.alusrc  = 1'b1;
                    w_dec.memread = 1'b1;
                    w_reads_rs    = 1'b1;
                end
                c_op_sw: begin
                    w_dec.valid    = 1'b1;
                    w_dec.alusrc   = 1'b1;
                    w_dec.memwrite = 1'b1;
                    w_reads_rs     = 1'b1;
                    w_reads_rt     = 1'b1;
                end
                c_op_beq: begin
                    w_dec.valid  = 1'b1;
                    w_dec.branch = 1'b1;
                    w_dec.aluop  = 3'b001;
                    w_reads_rs   = 1'b1;
                    w_reads_rt   = 1'b1;
                end
                c_op_j: begin
                    w_dec.valid = 1'b1;
                    w_jump      = 1'b1;
                end
                c_op_jal: begin
                    w_dec.valid = 1'b1;
                    w_dec.wen   = 1'b1;
                    w_dec.jal   = 1'b1;
                    w_jump      = 1'b1;
                end
                c_op_jr: begin
                    w_dec.valid = 1'b1;
                    w_jr        = 1'b1;
                    w_reads_rs  = 1'b1;
                end
                default: ;
            endcase
        end

        if (!w_dec.wen)
            w_dec.wdst = '0;
        else if (w_dec.jal)
            w_dec.wdst = REG_RA;
        else if (w_dec.regdst)
            w_dec.wdst = bus.rd_id;
        else
            w_dec.wdst = bus.rt_id;
    end

    // ------------------------------------------------------------------
    // Hazard detection and redirect resolution
    // ------------------------------------------------------------------
    assign w_branch_taken = r_idex.branch & r_idex.valid & bus.zero_ex;

`ifdef HAZARD_EN
    assign w_load_use = r_idex.memread & r_idex.valid & (r_idex.wdst != '0) &
                        ((w_reads_rs & (bus.rs_id == r_idex.wdst)) |
                         (w_reads_rt & (bus.rt_id == r_idex.wdst)));
`else
    logic w_unused_hazard;
    assign w_unused_hazard = ^{bus.rs_id, bus.rt_id, w_reads_rs, w_reads_rt};
    assign w_load_use      = 1'b0;
`endif

    always_comb begin
        w_pc_sel      = c_sel_pc4;
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        if (w_branch_taken) begin
            w_pc_sel      = c_sel_branch;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
        end else if (w_load_use) begin
            // Jump in ID waits until the load has moved on
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_bubble = 1'b1;
        end else if (w_jump) begin
            w_pc_sel     = c_sel_jump;
            w_ifid_flush = 1'b1;
        end else if (w_jr) begin
            w_pc_sel     = c_sel_jr;
            w_ifid_flush = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex  <= '0;
            r_exmem <= '0;
            r_memwb <= '0;
        end else begin
            r_idex           <= w_idex_bubble ? '0 : w_dec;
            r_exmem.valid    <= r_idex.valid;
            r_exmem.wen      <= r_idex.wen;
            r_exmem.memread  <= r_idex.memread;
            r_exmem.memwrite <= r_idex.memwrite;
            r_exmem.memtoreg <= r_idex.memtoreg;
            r_exmem.jal      <= r_idex.jal;
            r_exmem.wdst     <= r_idex.wdst;
            r_memwb.valid    <= r_exmem.valid;
            r_memwb.wen      <= r_exmem.wen;
            r_memwb.memtoreg <= r_exmem.memtoreg;
            r_memwb.jal      <= r_exmem.jal;
            r_memwb.wdst     <= r_exmem.wdst;
        end
    end

    logic w_unused_stage;
    assign w_unused_stage = ^{r_exmem.memtoreg & 1'b0};

    assign bus.alusrc_ex    = r_idex.alusrc;
    assign bus.regdst_ex    = r_idex.regdst;
    assign bus.branch_ex    = r_idex.branch;
    assign bus.memread_ex   = r_idex.memread;
    assign bus.aluop_ex     = r_idex.aluop;
    assign bus.wdst_ex      = r_idex.wdst;
    assign bus.valid_ex     = r_idex.valid;
    assign bus.memread_mem  = r_exmem.memread;
    assign bus.memwrite_mem = r_exmem.memwrite;
    assign bus.wdst_mem     = r_exmem.wdst;
    assign bus.valid_mem    = r_exmem.valid;
    assign bus.wen_wb       = r_memwb.wen;
    assign bus.memtoreg_wb  = r_memwb.memtoreg;
    assign bus.jal_wb       = r_memwb.jal;
    assign bus.wdst_wb      = r_memwb.wdst;
    assign bus.valid_wb     = r_memwb.valid;
    assign bus.pc_stall     = w_pc_stall;
    assign bus.ifid_stall   = w_ifid_stall;
    assign bus.ifid_flush   = w_ifid_flush;
    assign bus.pc_sel       = w_pc_sel;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
// ============================================================================
// Module   : tb_ctrl_pipe
// Brief    : Directed self-checking bench for ctrl_pipe (HAZARD_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_pipe;
    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_MUL  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd9;
    localparam logic [5:0] OP_SW   = 6'd10;
    localparam logic [5:0] OP_BEQ  = 6'd11;
    localparam logic [5:0] OP_J    = 6'd12;
    localparam logic [5:0] OP_JAL  = 6'd13;
    localparam logic [5:0] OP_JR   = 6'd14;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ctrl_pipe_if #(.OPW(6), .RW(5)) bus ();

    ctrl_pipe #(.OPW(6), .RW(5), .REG_RA(5'd31)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic drive(input logic v, input logic [5:0] op,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        bus.valid_id  = v;
        bus.opcode_id = op;
        bus.rs_id     = rs;
        bus.rt_id     = rt;
        bus.rd_id     = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        repeat (4) tick();
    endtask

    task automatic test_reset;
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        bus.zero_ex = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if ({bus.valid_ex, bus.valid_mem, bus.valid_wb} !== 3'b000) begin n_fail++; $display("FAIL rst_valid: got %b want 000", {bus.valid_ex, bus.valid_mem, bus.valid_wb}); end
        n_checks++; if ({bus.wen_wb, bus.memread_ex, bus.memwrite_mem, bus.jal_wb} !== 4'b0000) begin n_fail++; $display("FAIL rst_en: got %b want 0000", {bus.wen_wb, bus.memread_ex, bus.memwrite_mem, bus.jal_wb}); end
        n_checks++; if ({bus.wdst_ex, bus.wdst_mem, bus.wdst_wb} !== 15'd0) begin n_fail++; $display("FAIL rst_wdst: got %h want 0", {bus.wdst_ex, bus.wdst_mem, bus.wdst_wb}); end
        n_checks++; if ({bus.pc_sel, bus.pc_stall, bus.ifid_stall, bus.ifid_flush} !== 5'b00000) begin n_fail++; $display("FAIL rst_ctl: got %b want 00000", {bus.pc_sel, bus.pc_stall, bus.ifid_stall, bus.ifid_flush}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_pipeline;
        drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd7);
        #1;
        n_checks++; if ({bus.pc_sel, bus.ifid_flush, bus.pc_stall} !== 4'b0000) begin n_fail++; $display("FAIL add_ctl: got %b want 0000", {bus.pc_sel, bus.ifid_flush, bus.pc_stall}); end
        tick();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        n_checks++; if ({bus.valid_ex, bus.regdst_ex, bus.alusrc_ex, bus.aluop_ex} !== 6'b110000) begin n_fail++; $display("FAIL add_ex: got %b want 110000", {bus.valid_ex, bus.regdst_ex, bus.alusrc_ex, bus.aluop_ex}); end
        n_checks++; if (bus.wdst_ex !== 5'd7) begin n_fail++; $display("FAIL add_wdst_ex: got %0d want 7", bus.wdst_ex); end
        tick();
        n_checks++; if ({bus.valid_mem, bus.wdst_mem} !== {1'b1, 5'd7}) begin n_fail++; $display("FAIL add_mem: got %b/%0d want 1/7", bus.valid_mem, bus.wdst_mem); end
        tick();
        n_checks++; if ({bus.valid_wb, bus.wen_wb, bus.memtoreg_wb, bus.jal_wb} !== 4'b1110) begin n_fail++; $display("FAIL add_wb: got %b want 1110", {bus.valid_wb, bus.wen_wb, bus.memtoreg_wb, bus.jal_wb}); end
        n_checks++; if (bus.wdst_wb !== 5'd7) begin n_fail++; $display("FAIL add_wdst_wb: got %0d want 7", bus.wdst_wb); end
        drain();
    endtask

    task automatic test_back_to_back;
        drive(1'b1, OP_MUL, 5'd1, 5'd2, 5'd3);
        tick();
        n_checks++; if ({bus.aluop_ex, bus.wdst_ex} !== {3'b101, 5'd3}) begin n_fail++; $display("FAIL mul_ex: got %b/%0d want 101/3", bus.aluop_ex, bus.wdst_ex); end
        drive(1'b1, OP_SUB, 5'd1, 5'd2, 5'd4);
        tick();
        n_checks++; if ({bus.aluop_ex, bus.wdst_ex, bus.wdst_mem} !== {3'b001, 5'd4, 5'd3}) begin n_fail++; $display("FAIL sub_ex: got %b/%0d/%0d want 001/4/3", bus.aluop_ex, bus.wdst_ex, bus.wdst_mem); end
        drive(1'b1, OP_ADDI, 5'd1, 5'd8, 5'd9);
        tick();
        n_checks++; if ({bus.alusrc_ex, bus.regdst_ex, bus.wdst_ex} !== {2'b10, 5'd8}) begin n_fail++; $display("FAIL addi_ex: got %b%b/%0d want 10/8", bus.alusrc_ex, bus.regdst_ex, bus.wdst_ex); end
        n_checks++; if ({bus.wen_wb, bus.wdst_wb, bus.wdst_mem} !== {1'b1, 5'd3, 5'd4}) begin n_fail++; $display("FAIL b2b_wb: got %b/%0d/%0d want 1/3/4", bus.wen_wb, bus.wdst_wb, bus.wdst_mem); end
        drive(1'b1, OP_SW, 5'd1, 5'd6, 5'd0);
        tick();
        n_checks++; if ({bus.valid_ex, bus.alusrc_ex, bus.memread_ex} !== 3'b110) begin n_fail++; $display("FAIL sw_ex: got %b want 110", {bus.valid_ex, bus.alusrc_ex, bus.memread_ex}); end
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        n_checks++; if ({bus.valid_mem, bus.memwrite_mem, bus.memread_mem} !== 3'b110) begin n_fail++; $display("FAIL sw_mem: got %b want 110", {bus.valid_mem, bus.memwrite_mem, bus.memread_mem}); end
        tick();
        n_checks++; if ({bus.valid_wb, bus.wen_wb} !== 2'b10) begin n_fail++; $display("FAIL sw_wb: got %b want 10", {bus.valid_wb, bus.wen_wb}); end
        drain();
    endtask

    task automatic test_load_use;
        drive(1'b1, OP_LW, 5'd1, 5'd4, 5'd0);
        tick();
        drive(1'b1, OP_ADD, 5'd4, 5'd2, 5'd5);
        #1;
        n_checks++; if ({bus.memread_ex, bus.wdst_ex} !== {1'b1, 5'd4}) begin n_fail++; $display("FAIL lw_ex: got %b/%0d want 1/4", bus.memread_ex, bus.wdst_ex); end
`ifdef HAZARD_EN
        n_checks++; if ({bus.pc_stall, bus.ifid_stall, bus.pc_sel, bus.ifid_flush} !== 5'b11000) begin n_fail++; $display("FAIL lu_stall: got %b want 11000", {bus.pc_stall, bus.ifid_stall, bus.pc_sel, bus.ifid_flush}); end
        tick();
        n_checks++; if ({bus.valid_ex, bus.memread_mem} !== 2'b01) begin n_fail++; $display("FAIL lu_bubble: got %b want 01", {bus.valid_ex, bus.memread_mem}); end
        #1;
        n_checks++; if ({bus.pc_stall, bus.ifid_stall} !== 2'b00) begin n_fail++; $display("FAIL lu_one_cycle: got %b want 00", {bus.pc_stall, bus.ifid_stall}); end
        tick();
`else
        n_checks++; if ({bus.pc_stall, bus.ifid_stall} !== 2'b00) begin n_fail++; $display("FAIL lu_nostall: got %b want 00", {bus.pc_stall, bus.ifid_stall}); end
        tick();
`endif
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        n_checks++; if ({bus.valid_ex, bus.wdst_ex} !== {1'b1, 5'd5}) begin n_fail++; $display("FAIL lu_add_ex: got %b/%0d want 1/5", bus.valid_ex, bus.wdst_ex); end
        drain();
    endtask

    task automatic test_load_r0;
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd0);
        tick();
        drive(1'b1, OP_ADD, 5'd0, 5'd0, 5'd5);
        #1;
        n_checks++; if ({bus.memread_ex, bus.pc_stall, bus.ifid_stall} !== 3'b100) begin n_fail++; $display("FAIL r0_nostall: got %b want 100", {bus.memread_ex, bus.pc_stall, bus.ifid_stall}); end
        tick();
        n_checks++; if (bus.valid_ex !== 1'b1) begin n_fail++; $display("FAIL r0_valid: got %b want 1", bus.valid_ex); end
        drain();
    endtask

    task automatic test_jump_vs_stall;
        drive(1'b1, OP_LW, 5'd1, 5'd4, 5'd0);
        tick();
        drive(1'b1, OP_JR, 5'd4, 5'd0, 5'd0);
        #1;
`ifdef HAZARD_EN
        n_checks++; if ({bus.pc_sel, bus.ifid_flush, bus.pc_stall} !== 4'b0001) begin n_fail++; $display("FAIL jr_held: got %b want 0001", {bus.pc_sel, bus.ifid_flush, bus.pc_stall}); end
        tick();
        #1;
`endif
        n_checks++; if ({bus.pc_sel, bus.ifid_flush, bus.pc_stall} !== 4'b1110) begin n_fail++; $display("FAIL jr_redirect: got %b want 1110", {bus.pc_sel, bus.ifid_flush, bus.pc_stall}); end
        drain();
    endtask

    task automatic test_branch;
        drive(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0);
        tick();
        n_checks++; if ({bus.branch_ex, bus.aluop_ex, bus.valid_ex} !== 5'b10011) begin n_fail++; $display("FAIL beq_ex: got %b want 10011", {bus.branch_ex, bus.aluop_ex, bus.valid_ex}); end
        bus.zero_ex = 1'b1;
        drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd9);
        #1;
        n_checks++; if ({bus.pc_sel, bus.ifid_flush, bus.pc_stall} !== 4'b0110) begin n_fail++; $display("FAIL br_taken: got %b want 0110", {bus.pc_sel, bus.ifid_flush, bus.pc_stall}); end
        tick();
        bus.zero_ex = 1'b0;
        n_checks++; if (bus.valid_ex !== 1'b0) begin n_fail++; $display("FAIL br_squash: got %b want 0", bus.valid_ex); end
        drive(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0);
        tick();
        drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd9);
        #1;
        n_checks++; if ({bus.pc_sel, bus.ifid_flush} !== 3'b000) begin n_fail++; $display("FAIL br_not_taken: got %b want 000", {bus.pc_sel, bus.ifid_flush}); end
        tick();
        n_checks++; if ({bus.valid_ex, bus.wdst_ex} !== {1'b1, 5'd9}) begin n_fail++; $display("FAIL br_nt_ex: got %b/%0d want 1/9", bus.valid_ex, bus.wdst_ex); end
        drive(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0);
        tick();
        bus.zero_ex = 1'b1;
        drive(1'b1, OP_JAL, 5'd0, 5'd0, 5'd0);
        #1;
        n_checks++; if ({bus.pc_sel, bus.ifid_flush} !== 3'b011) begin n_fail++; $display("FAIL br_over_jal: got %b want 011", {bus.pc_sel, bus.ifid_flush}); end
        tick();
        bus.zero_ex = 1'b0;
        n_checks++; if (bus.valid_ex !== 1'b0) begin n_fail++; $display("FAIL br_jal_squash: got %b want 0", bus.valid_ex); end
        drain();
    endtask

    task automatic test_jumps;
        drive(1'b1, OP_JAL, 5'd0, 5'd0, 5'd0);
        #1;
        n_checks++; if ({bus.pc_sel, bus.ifid_flush, bus.pc_stall} !== 4'b1010) begin n_fail++; $display("FAIL jal_ctl: got %b want 1010", {bus.pc_sel, bus.ifid_flush, bus.pc_stall}); end
        tick();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        n_checks++; if ({bus.valid_ex, bus.wdst_ex} !== {1'b1, 5'd31}) begin n_fail++; $display("FAIL jal_ex: got %b/%0d want 1/31", bus.valid_ex, bus.wdst_ex); end
        tick();
        tick();
        n_checks++; if ({bus.wen_wb, bus.jal_wb, bus.wdst_wb} !== {2'b11, 5'd31}) begin n_fail++; $display("FAIL jal_wb: got %b%b/%0d want 11/31", bus.wen_wb, bus.jal_wb, bus.wdst_wb); end
        drive(1'b1, OP_J, 5'd0, 5'd0, 5'd0);
        #1;
        n_checks++; if ({bus.pc_sel, bus.ifid_flush} !== 3'b101) begin n_fail++; $display("FAIL j_ctl: got %b want 101", {bus.pc_sel, bus.ifid_flush}); end
        drive(1'b1, OP_JR, 5'd3, 5'd0, 5'd0);
        #1;
        n_checks++; if ({bus.pc_sel, bus.ifid_flush} !== 3'b111) begin n_fail++; $display("FAIL jr_ctl: got %b want 111", {bus.pc_sel, bus.ifid_flush}); end
        drive(1'b1, 6'd63, 5'd0, 5'd0, 5'd0);
        tick();
        n_checks++; if ({bus.valid_ex, bus.pc_sel, bus.ifid_flush} !== 4'b0000) begin n_fail++; $display("FAIL illegal_op: got %b want 0000", {bus.valid_ex, bus.pc_sel, bus.ifid_flush}); end
        drain();
    endtask

    task automatic test_reset_mid_stall;
        drive(1'b1, OP_LW, 5'd1, 5'd4, 5'd0);
        tick();
        drive(1'b1, OP_ADD, 5'd4, 5'd2, 5'd5);
        #2;
        rst_n = 1'b0;
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        #1;
        n_checks++; if ({bus.valid_ex, bus.memread_ex, bus.wdst_ex} !== 7'd0) begin n_fail++; $display("FAIL async_rst_ex: got %b want 0", {bus.valid_ex, bus.memread_ex, bus.wdst_ex}); end
        n_checks++; if ({bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.pc_sel} !== 5'd0) begin n_fail++; $display("FAIL async_rst_ctl: got %b want 0", {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.pc_sel}); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_pipeline();
        test_back_to_back();
        test_load_use();
        test_load_r0();
        test_jump_vs_stall();
        test_branch();
        test_jumps();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the five-stage CPU. Decodes the ID-stage opcode into the full control bundle, including jump, jal and jr, and carries each stage's share through ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards and resolves branch and jump redirects, driving PC/IF-ID stall, flush and PC-select to the datapath. Successor to the single-cycle combinational control decoder, generalised in register-address width and opcode width.

## Interface
- OPW, 6: opcode width; decode uses the `define.v` opcode macros.
- RW, 5: register address width.
- REG_RA, {RW{1'b1}}: link register written by JAL.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- valid_id  in  1  IF/ID holds a real instruction
- opcode_id  in  OPW  ID-stage opcode
- rs_id, rt_id, rd_id  in  RW  ID-stage register fields
- zero_ex  in  1  ALU zero flag from EX
- alusrc_ex, regdst_ex, branch_ex, memread_ex  out  1  EX-stage controls
- aluop_ex  out  3  EX-stage ALU op
- memread_mem, memwrite_mem  out  1  MEM-stage controls
- wen_wb, memtoreg_wb, jal_wb  out  1  WB-stage controls
- wdst_ex, wdst_mem, wdst_wb  out  RW  resolved destination register per stage
- valid_ex, valid_mem, valid_wb  out  1  stage holds a real instruction
- pc_stall, ifid_stall, ifid_flush  out  1  hazard/redirect controls (combinational)
- pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs value (JR)

One clock; reset is asynchronous and active-low.

## Operation
- Decode, ADD/SUB/AND/XOR/COM/MUL: wen=1, alusrc=0, regdst=1, memtoreg=1, aluop=opcode[2:0]. These read rs and rt.
- Decode, ADDI: wen=1, alusrc=1, regdst=0. Reads rs.
- Decode, LW: wen=1, alusrc=1, regdst=0, memread=1, memtoreg=0. Reads rs.
- Decode, SW: wen=0, alusrc=1, memwrite=1. Reads rs and rt.
- Decode, BEQ: wen=0, branch=1, aluop=3'b001. Reads rs and rt.
- Decode, J: all write/memory enables 0.
- Decode, JAL: wen=1, jal=1, destination REG_RA.
- Decode, JR: all enables 0. Reads rs.
- Any other opcode, or valid_id=0: bubble; all enables 0, valid 0.
- Destination: jal → REG_RA; regdst=1 → rd_id; otherwise rt_id.
- The per-stage valid and enable bits advance one stage per clock.
- Resolution priority, evaluated every cycle:
  1. Branch taken (branch_ex & valid_ex & zero_ex): pc_sel=01, ifid_flush=1, ID/EX loads a bubble, no stall.
  2. Load-use hazard (memread_ex & valid_ex & wdst_ex≠0 & wdst_ex equals an rs/rt the ID instruction reads): pc_stall=1, ifid_stall=1, ID/EX loads a bubble. A jump in ID is not acted on this cycle.
  3. Jump in ID (J/JAL → pc_sel=10, JR → pc_sel=11): ifid_flush=1. The jump itself enters ID/EX normally.
  4. Otherwise pc_sel=00, with stall and flush deasserted.
- Register 0 never creates a hazard.

## Timing
- The stage registers update on the rising edge of clk.
- pc_stall, ifid_stall, ifid_flush and pc_sel are combinational from the current ID/EX contents and the ID inputs.
- Latency: decode to *_ex is 1 cycle, *_mem is 2 cycles, *_wb is 3 cycles.
- Load-use costs exactly one bubble. Taken branch costs two squashed instructions (IF/ID and ID/EX). Jump costs one.
- Reset (async, any time, including mid-stall or mid-flush):
  - Every registered output goes to 0, and the wdst_* outputs go to 0.
  - Combinational outputs then evaluate to 0 / pc_sel=00 while valid_id=0.
- Simultaneous branch-taken and load-use: the branch wins; stall stays deasserted.

## Configuration
- HAZARD_EN defined: load-use detection as above.
- HAZARD_EN undefined:
  - pc_stall and ifid_stall are tied 0, and load-use produces no bubble; software must insert NOPs.
  - Branch and jump redirect and flush are unchanged.

## Test plan
- ADD with rd=7, then three bubbles: wen_wb=1, memtoreg_wb=1, wdst_wb=7 on cycle 3; aluop_ex=opcode[2:0] on cycle 1.
- LW rt=4, then ADD rs=4: pc_stall=ifid_stall=1 for exactly one cycle and valid_ex=0 the next cycle. Without HAZARD_EN, no stall.
- LW rt=0, then ADD rs=0: no stall.
- BEQ with zero_ex=1 in EX: pc_sel=01, ifid_flush=1, and the next valid_ex=0. With zero_ex=0: pc_sel=00 and no flush.
- JAL in ID: pc_sel=10, ifid_flush=1; three cycles later wen_wb=1, jal_wb=1, wdst_wb=31. JR: pc_sel=11.
- Assert rst_n=0 mid-stall: all outputs 0 immediately, with no clock edge needed.
